// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer.
// Each input beat is routed by io_in_dest into a one-entry holding slot for
// that output. Every slot drains independently under its own handshake, and a
// slot may be drained and refilled in the same cycle.
module stream_demux #(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         io_in_valid,
    output logic         io_in_ready,
    input  logic [W-1:0] io_in_bits,
    input  logic [1:0]   io_in_dest,
    output logic         io_out_0_valid,
    input  logic         io_out_0_ready,
    output logic [W-1:0] io_out_0_bits,
    output logic         io_out_1_valid,
    input  logic         io_out_1_ready,
    output logic [W-1:0] io_out_1_bits,
    output logic         io_out_2_valid,
    input  logic         io_out_2_ready,
    output logic [W-1:0] io_out_2_bits,
    output logic         io_out_3_valid,
    input  logic         io_out_3_ready,
    output logic [W-1:0] io_out_3_bits,
    output logic         io_fire,
    output logic [7:0]   io_count
);

    // Per-slot occupancy and payload, plus the accepted-beat counter.
    logic [N-1:0] full_r;
    logic [W-1:0] data_r [N];
    logic [7:0]   cnt_r;

    logic [N-1:0] out_ready_s;
    logic [N-1:0] load_s;
    logic [N-1:0] drain_s;
    logic         in_ready_s;
    logic         fire_s;

    assign out_ready_s = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

    // Input acceptance, per-slot load select and per-slot drain detection.
    always_comb begin
        in_ready_s = 1'b0;
        fire_s     = 1'b0;
        load_s     = {N{1'b0}};
        drain_s    = full_r & out_ready_s;
        if (reset) begin
            // Nothing is accepted while the block is held in reset.
            in_ready_s = 1'b0;
        end else begin
            // A full slot can still take a beat if its consumer drains it this cycle.
            in_ready_s = !full_r[io_in_dest] | out_ready_s[io_in_dest];
        end
        fire_s = io_in_valid & in_ready_s;
        if (fire_s) begin
            load_s[io_in_dest] = 1'b1;
        end else begin
            load_s = {N{1'b0}};
        end
    end

    // Slot state: a load wins over a drain on the same slot; other slots drain in parallel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r <= {N{1'b0}};
            for (int k = 0; k < N; k++) begin
                data_r[k] <= {W{1'b0}};
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (load_s[k]) begin
                    full_r[k] <= 1'b1;
                    data_r[k] <= io_in_bits;
                end else if (drain_s[k]) begin
                    full_r[k] <= 1'b0;
                end
            end
        end
    end

    // Free-running count of accepted input beats, wrapping modulo 256.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 8'd0;
        end else if (fire_s) begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign io_in_ready    = in_ready_s;
    assign io_fire        = fire_s;
    assign io_count       = cnt_r;
    assign io_out_0_valid = full_r[0];
    assign io_out_1_valid = full_r[1];
    assign io_out_2_valid = full_r[2];
    assign io_out_3_valid = full_r[3];
    assign io_out_0_bits  = data_r[0];
    assign io_out_1_bits  = data_r[1];
    assign io_out_2_bits  = data_r[2];
    assign io_out_3_bits  = data_r[3];

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux.
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, combinational outputs 1 unit after a change.
module tb_stream_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_bits;
    logic [1:0] in_dest;
    logic       in_ready;
    logic [3:0] ordy;
    logic [3:0] ov;
    logic [7:0] ob [4];
    logic       fire;
    logic [7:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_demux #(.W(8), .N(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .io_in_valid    (in_valid),
        .io_in_ready    (in_ready),
        .io_in_bits     (in_bits),
        .io_in_dest     (in_dest),
        .io_out_0_valid (ov[0]),
        .io_out_0_ready (ordy[0]),
        .io_out_0_bits  (ob[0]),
        .io_out_1_valid (ov[1]),
        .io_out_1_ready (ordy[1]),
        .io_out_1_bits  (ob[1]),
        .io_out_2_valid (ov[2]),
        .io_out_2_ready (ordy[2]),
        .io_out_2_bits  (ob[2]),
        .io_out_3_valid (ov[3]),
        .io_out_3_ready (ordy[3]),
        .io_out_3_bits  (ob[3]),
        .io_fire        (fire),
        .io_count       (count)
    );

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; in_bits = 8'h99; in_dest = 2'd1; ordy = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (ov !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b want 0000", ov); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if (fire !== 1'b0) begin bad++; $display("FAIL reset_fire: got %b want 0", fire); end
        for (int k = 0; k < 4; k++) begin
            total++; if (ob[k] !== 8'h00) begin bad++; $display("FAIL reset_bits%0d: got %h want 00", k, ob[k]); end
        end
        in_valid = 1'b0;
        reset = 1'b0;
        // Fill slots 0 and 2, then hit reset in the middle of a cycle.
        @(negedge clk); in_valid = 1'b1; in_bits = 8'h01; in_dest = 2'd0;
        @(negedge clk); in_bits = 8'h02; in_dest = 2'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (ov !== 4'b0101) begin bad++; $display("FAIL prefill_valid: got %b want 0101", ov); end
        total++; if (count !== 8'd2) begin bad++; $display("FAIL prefill_count: got %0d want 2", count); end
        #2 reset = 1'b1;
        #1;
        total++; if (ov !== 4'b0000) begin bad++; $display("FAIL async_reset_valid: got %b want 0000", ov); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL async_reset_count: got %0d want 0", count); end
        @(negedge clk); reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            in_dest = 2'(d); #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready%0d: got %b want 1", d, in_ready); end
        end
    endtask

    task automatic test_single_routing;
        logic [7:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        ordy = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); in_valid = 1'b1; in_bits = vals[k]; in_dest = 2'(k); #1;
            total++; if (fire !== 1'b1) begin bad++; $display("FAIL route_fire%0d: got %b want 1", k, fire); end
            @(posedge clk); #1;
            total++; if (ov[k] !== 1'b1) begin bad++; $display("FAIL route_valid%0d: got %b want 1", k, ov[k]); end
            total++; if (ob[k] !== vals[k]) begin bad++; $display("FAIL route_bits%0d: got %h want %h", k, ob[k], vals[k]); end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (ov !== 4'b1111) begin bad++; $display("FAIL route_all_valid: got %b want 1111", ov); end
        for (int k = 0; k < 4; k++) begin
            total++; if (ob[k] !== vals[k]) begin bad++; $display("FAIL route_hold%0d: got %h want %h", k, ob[k], vals[k]); end
        end
        total++; if (count !== 8'd4) begin bad++; $display("FAIL route_count: got %0d want 4", count); end
    endtask

    task automatic test_backpressure;
        // Replace 0x22 with 0xAA by draining and refilling slot 1 in one cycle.
        @(negedge clk); in_valid = 1'b1; in_bits = 8'hAA; in_dest = 2'd1; ordy = 4'b0010; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL refill_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        total++; if (ob[1] !== 8'hAA || ov[1] !== 1'b1) begin bad++; $display("FAIL refill_slot: got %h/%b want aa/1", ob[1], ov[1]); end
        @(negedge clk); ordy = 4'b0000; in_bits = 8'hBB; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready: got %b want 0", in_ready); end
        total++; if (fire !== 1'b0) begin bad++; $display("FAIL bp_fire: got %b want 0", fire); end
        @(posedge clk); #1;
        total++; if (ob[1] !== 8'hAA || ov[1] !== 1'b1) begin bad++; $display("FAIL bp_hold: got %h/%b want aa/1", ob[1], ov[1]); end
        total++; if (count !== 8'd5) begin bad++; $display("FAIL bp_count: got %0d want 5", count); end
        @(negedge clk); ordy = 4'b0010; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        total++; if (ob[1] !== 8'hBB || ov[1] !== 1'b1) begin bad++; $display("FAIL bp_new: got %h/%b want bb/1", ob[1], ov[1]); end
        total++; if (count !== 8'd6) begin bad++; $display("FAIL bp_count2: got %0d want 6", count); end
        @(negedge clk); in_valid = 1'b0; ordy = 4'b0000;
    endtask

    task automatic test_back_to_back;
        ordy = 4'b1000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); in_valid = 1'b1; in_bits = 8'(i); in_dest = 2'd3; #1;
            total++; if (fire !== 1'b1) begin bad++; $display("FAIL stream_fire%0d: got %b want 1", i, fire); end
            @(posedge clk); #1;
            total++; if (ov[3] !== 1'b1 || ob[3] !== 8'(i)) begin bad++; $display("FAIL stream_out%0d: got %h/%b want %h/1", i, ob[3], ov[3], 8'(i)); end
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        total++; if (ov[3] !== 1'b0) begin bad++; $display("FAIL stream_empty: got %b want 0", ov[3]); end
        total++; if (count !== 8'd16) begin bad++; $display("FAIL stream_count: got %0d want 16", count); end
        total++; if (ov[2:0] !== 3'b111) begin bad++; $display("FAIL stream_others: got %b want 111", ov[2:0]); end
        @(negedge clk); ordy = 4'b0000;
    endtask

    task automatic test_parallel_drain;
        @(negedge clk); in_valid = 1'b1; in_bits = 8'h77; in_dest = 2'd3;
        @(posedge clk); #1;
        total++; if (ov !== 4'b1111) begin bad++; $display("FAIL pd_full: got %b want 1111", ov); end
        @(negedge clk); ordy = 4'b1111; in_bits = 8'h5A; in_dest = 2'd2; #1;
        total++; if (fire !== 1'b1) begin bad++; $display("FAIL pd_fire: got %b want 1", fire); end
        @(posedge clk); #1;
        total++; if (ov !== 4'b0100) begin bad++; $display("FAIL pd_valid: got %b want 0100", ov); end
        total++; if (ob[2] !== 8'h5A) begin bad++; $display("FAIL pd_bits: got %h want 5a", ob[2]); end
        total++; if (count !== 8'd18) begin bad++; $display("FAIL pd_count: got %0d want 18", count); end
        @(negedge clk); in_valid = 1'b0; ordy = 4'b0000;
    endtask

    task automatic test_counter_wrap;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        total++; if (count !== 8'd0) begin bad++; $display("FAIL wrap_start: got %0d want 0", count); end
        ordy = 4'b0001;
        for (int i = 0; i < 257; i++) begin
            @(negedge clk); in_valid = 1'b1; in_bits = 8'(i); in_dest = 2'd0;
            @(posedge clk); #1;
            if (i == 255) begin
                total++; if (count !== 8'd0) begin bad++; $display("FAIL wrap_256: got %0d want 0", count); end
            end
        end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (count !== 8'd1) begin bad++; $display("FAIL wrap_257: got %0d want 1", count); end
        total++; if (ov[0] !== 1'b1 || ob[0] !== 8'h00) begin bad++; $display("FAIL wrap_last: got %h/%b want 00/1", ob[0], ov[0]); end
        ordy = 4'b0000;
    endtask

    initial begin
        test_reset;
        test_single_routing;
        test_backpressure;
        test_back_to_back;
        test_parallel_drain;
        test_counter_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N stream demultiplexer: accepts one ready/valid stream carrying a destination index and routes each beat into a one-entry holding register for the selected output port. It is the splitting counterpart to the priority arbiter, which merges N streams into one. Together they form the fan-in/fan-out pair of the stdlib stream fabric. Each output drains independently under its own ready/valid handshake, so a stalled consumer only blocks beats addressed to it.

## Interface
- W, 8, data width of io_in_bits and every io_out_k_bits (elaboration-time constant)
- N, 4, number of output ports; dest width is log2(N) = 2 (elaboration-time constant)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk
- io_in_valid  input  1  upstream beat present
- io_in_ready  output  1  demux can accept the beat this cycle
- io_in_bits  input  W  payload
- io_in_dest  input  2  destination output index, 0..N-1
- io_out_k_valid  output  1  slot k holds a beat (k = 0..3)
- io_out_k_ready  input  1  consumer k takes the beat this cycle
- io_out_k_bits  output  W  payload held in slot k
- io_fire  output  1  io_in_valid & io_in_ready, i.e. an input beat is accepted this cycle
- io_count  output  8  free-running count of accepted input beats, mod 256

## Operation
- State per slot k: full_k (1 bit) and data_k (W bits). Global state: cnt (8 bits).
- Reset values: every full_k = 0, every data_k = 0, cnt = 0.
- Output values while in reset: all io_out_k_valid = 0, all io_out_k_bits = 0, io_count = 0, io_fire = 0.
- io_out_k_valid = full_k; io_out_k_bits = data_k, registered directly with no combinational path from the input.
- drain_k = full_k & io_out_k_ready.
- io_in_ready = !full[io_in_dest] | io_out_ready[io_in_dest]:
  - this is a pass-through refill, i.e. combinational from io_in_dest and io_out_dest_ready;
  - io_in_ready does not depend on io_in_valid.
- On io_fire, slot d = io_in_dest is loaded: full_d <= 1, data_d <= io_in_bits.
- For every slot k not loaded this cycle: if drain_k, then full_k <= 0; data_k is retained, with no clearing required.
- Simultaneous drain and load on the same slot: the load wins, full stays 1, and data is replaced by the new beat. This gives full throughput of 1 beat/cycle per port.
- Drains on other slots occur in parallel with a load on slot d. Up to N slots may drain in one cycle.
- cnt <= cnt + 1 on io_fire and wraps 255 -> 0. io_count = cnt.
- io_in_dest is sampled only when io_in_valid = 1; its value is ignored otherwise.
- Beats to the same destination are delivered in acceptance order. No ordering is guaranteed across destinations.
- A beat blocked on a full slot blocks the input (head-of-line), even if other slots are empty.
- Reset asserted mid-operation: all held beats are discarded and all valids drop asynchronously. A handshake in flight that cycle is lost.

## Timing
- Latency: a beat accepted at edge t appears as io_out_d_valid = 1 immediately after edge t. The consumer can take it at edge t+1.
- Sustained throughput: 1 beat/cycle to any single destination while its consumer holds ready = 1.
- Backpressure:
  - with slot d full and io_out_d_ready = 0, io_in_ready = 0 for dest d;
  - the upstream must hold valid, bits and dest stable until fire.
- Reset release: io_in_ready = 1 for any dest on the first cycle after reset deasserts, since all slots are empty.

## Test plan
- Reset: assert reset asynchronously mid-cycle with slots 0 and 2 full. Required: io_out_0_valid and io_out_2_valid fall without a clock edge, and io_count reads 0. After release, io_in_ready = 1.
- Single routing: send 0x11 to dest 0, 0x22 to dest 1, 0x33 to dest 2 and 0x44 to dest 3, with all consumers ready = 0. Required:
  - each io_out_k_bits holds the matching value, with valid = 1 one cycle after each fire;
  - io_count = 4.
- Backpressure: slot 1 holds 0xAA with io_out_1_ready = 0, and the input offers 0xBB to dest 1. Required:
  - io_in_ready = 0 and 0xAA stays put;
  - raising io_out_1_ready gives io_in_ready = 1 the same cycle, and 0xBB is in slot 1 after that edge.
- Streaming: 10 back-to-back beats 0..9 to dest 3 with io_out_3_ready = 1 throughout. Required: io_fire is high every cycle, and output 3 delivers 0..9 in order with no bubbles.
- Parallel drain: slots 0..3 all full, and all readies rise in one cycle while the input loads 0x5A into dest 2. Required: after the edge, only slot 2 is valid and holds 0x5A.
- Counter wrap: 257 accepted beats. Required: io_count reads 1.
